// File: rtl/cla_addsub_seq.sv
// ---------------------------------------------------------------------------
// cla_addsub_seq
//   Multi-cycle carry-lookahead adder/subtractor. A WIDTH-bit operation is
//   split into N = WIDTH/CHUNK slices, one slice per clock, with the slice
//   carry held in a register between cycles. Inside a slice, 4-bit CLA groups
//   produce group propagate/generate and a second-level lookahead unit
//   produces every group carry-in directly, so no carry ripples between
//   groups.
//
//   WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub    operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum               result, valid while out_valid=1
//   cout              carry out of MSB (subtract: 1 = no borrow)
//   overflow          signed overflow (carry into MSB ^ carry out of MSB)
//   zero              sum == 0
//   busy              not IDLE
// ---------------------------------------------------------------------------

// 4-bit CLA group: bit sums plus group propagate/generate for the next level.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gp,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// Second-level lookahead: every group carry is a flat sum of products of the
// group P/G terms and the slice carry-in. The loops unroll into that flat
// form; no carry term feeds another carry term.
module cla_lookahead #(
  parameter int GROUPS = 2
) (
  input  logic [GROUPS-1:0] gp,
  input  logic [GROUPS-1:0] gg,
  input  logic              ci,
  output logic [GROUPS:0]   c
);
  logic [GROUPS:0] c_int;
  logic            acc;
  logic            term;

  always_comb begin
    c_int    = '0;
    acc      = 1'b0;
    term     = 1'b0;
    c_int[0] = ci;
    for (int j = 1; j <= GROUPS; j++) begin
      // carry-in term propagated through groups 0..j-1
      term = ci;
      for (int m = 0; m < j; m++) term = term & gp[m];
      acc = term;
      // group i generates, propagated through groups i+1..j-1
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        acc = acc | term;
      end
      c_int[j] = acc;
    end
  end

  assign c = c_int;
endmodule

module cla_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);
  localparam int N      = WIDTH / CHUNK;
  localparam int GROUPS = CHUNK / 4;
  localparam int IDXW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic             carry_q, carry_d;
  res_t             res_q, res_d;

  // ---- slice datapath ----
  int               base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS:0]   grp_c;
  logic             slice_co;
  logic             slice_ov;

  always_comb begin
    base    = CHUNK * int'(idx_q);
    slice_a = a_q[base +: CHUNK];
    slice_b = b_q[base +: CHUNK];
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    cla_group4 u_grp (
      .a  (slice_a[4*g +: 4]),
      .b  (slice_b[4*g +: 4]),
      .ci (grp_c[g]),
      .s  (slice_s[4*g +: 4]),
      .gp (grp_p[g]),
      .gg (grp_g[g])
    );
  end

  cla_lookahead #(.GROUPS(GROUPS)) u_la (
    .gp (grp_p),
    .gg (grp_g),
    .ci (carry_q),
    .c  (grp_c)
  );

  // Carry into the MSB falls out of s = a ^ b ^ c at that bit, so the group
  // module need not export its internal bit carries.
  always_comb begin
    slice_co = grp_c[GROUPS];
    slice_ov = (slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1]) ^ slice_co;
  end

  // ---- control ----
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;      // subtract forces the +1 of two's complement
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d.sum[base +: CHUNK] = slice_s;
        carry_d                  = slice_co;
        if (idx_q == LAST) begin
          res_d.cout = slice_co;
          res_d.ovf  = slice_ov;
          res_d.zero = ~|res_d.sum;  // includes the slice just written
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
    end
  end

  // All outputs come straight from registers.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = res_q.sum;
  assign cout      = res_q.cout;
  assign overflow  = res_q.ovf;
  assign zero      = res_q.zero;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: three instances (32/8, 16/4, 24/8) on one clock.
// A behavioural model built on plain wide arithmetic and a per-instance
// "cycles left" counter predicts every output; one compare process checks
// each instance on every falling edge. Directed cases pin literal values.
module tb_cla_addsub_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid, out_ready, cin, sub;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v, zero_v, busy_v;
  logic [31:0] sum0;
  logic [15:0] sum1;
  logic [23:0] sum2;
  logic [31:0] sum_v [3];

  assign sum_v[0] = sum0;
  assign sum_v[1] = {16'h0, sum1};
  assign sum_v[2] = {8'h0, sum2};

  cla_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready[0]), .sum(sum0),
    .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]), .busy(busy_v[0]));

  cla_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready[1]), .sum(sum1),
    .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]), .busy(busy_v[1]));

  cla_addsub_seq #(.WIDTH(24), .CHUNK(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][23:0]), .b(b_v[2][23:0]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready[2]), .sum(sum2),
    .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]), .busy(busy_v[2]));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
  endtask

  function automatic int wdt(input int k);
    case (k)
      0:       return 32;
      1:       return 16;
      default: return 24;
    endcase
  endfunction

  function automatic int nsl(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  // Reference arithmetic: full-width add with one spare bit, signed overflow
  // from operand/result sign agreement.
  function automatic void calc(input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input logic sb,
                               output logic [31:0] s, output logic co,
                               output logic ov, output logic z);
    logic [32:0] full;
    logic [31:0] mask, aa, bb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa   = a & mask;
    bb   = (sb ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {32'h0, (sb | ci)};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    z    = (s == 32'h0);
  endfunction

  // ---- model state ----
  int          m_run  [3];
  logic        m_done [3];
  logic [31:0] m_sum  [3];
  logic        m_co   [3], m_ov [3], m_z [3];
  logic [31:0] p_sum  [3];
  logic        p_co   [3], p_ov [3], p_z [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_run[k] = 0; m_done[k] = 1'b0;
        m_sum[k] = '0; m_co[k] = 1'b0; m_ov[k] = 1'b0; m_z[k] = 1'b0;
      end else if (m_done[k]) begin
        if (out_ready[k]) m_done[k] = 1'b0;
      end else if (m_run[k] > 0) begin
        m_run[k] = m_run[k] - 1;
        if (m_run[k] == 0) begin
          m_done[k] = 1'b1;
          m_sum[k] = p_sum[k]; m_co[k] = p_co[k]; m_ov[k] = p_ov[k]; m_z[k] = p_z[k];
        end
      end else if (in_valid[k]) begin
        calc(wdt(k), a_v[k], b_v[k], cin[k], sub[k], p_sum[k], p_co[k], p_ov[k], p_z[k]);
        m_run[k] = nsl(k);
      end
    end
  end

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready",  k, {31'h0, in_ready_v[k]},  {31'h0, (m_run[k] == 0) && !m_done[k]});
        chk("busy",      k, {31'h0, busy_v[k]},      {31'h0, (m_run[k] != 0) || m_done[k]});
        chk("out_valid", k, {31'h0, out_valid_v[k]}, {31'h0, m_done[k]});
        chk("cout",      k, {31'h0, cout_v[k]},      {31'h0, m_co[k]});
        chk("overflow",  k, {31'h0, ovf_v[k]},       {31'h0, m_ov[k]});
        chk("zero",      k, {31'h0, zero_v[k]},      {31'h0, m_z[k]});
        if (m_run[k] == 0) chk("sum", k, sum_v[k], m_sum[k]);
      end
    end
  end

  // ---- stimulus helpers (called at #1 after a rising edge) ----
  task automatic apply(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    in_valid[k] = 1'b1; a_v[k] = a; b_v[k] = b; cin[k] = c; sub[k] = s;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", k, {31'h0, out_valid_v[k]}, 32'h1);
  endtask

  task automatic pop(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic res_chk(input int k, input string tag, input logic [31:0] es,
                         input logic eco, input logic eov, input logic ez);
    chk({tag, "_sum"},  k, sum_v[k], es);
    chk({tag, "_cout"}, k, {31'h0, cout_v[k]}, {31'h0, eco});
    chk({tag, "_ovf"},  k, {31'h0, ovf_v[k]},  {31'h0, eov});
    chk({tag, "_zero"}, k, {31'h0, zero_v[k]}, {31'h0, ez});
  endtask

  initial begin
    logic [31:0] ms;
    logic        mco, mov, mz;
    int          lat;

    rst_n     = 1'b0;
    in_valid  = 3'b001;          // handshake attempt while in reset
    out_ready = 3'b000;
    cin       = 3'b000;
    sub       = 3'b000;
    for (int k = 0; k < 3; k++) begin a_v[k] = 32'hDEAD_BEEF; b_v[k] = 32'h1; end

    // Reset held for three edges with in_valid high.
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready",  0, {31'h0, in_ready_v[0]},  32'h1);
    chk("rst_out_valid", 0, {31'h0, out_valid_v[0]}, 32'h0);
    chk("rst_busy",      0, {31'h0, busy_v[0]},      32'h0);
    res_chk(0, "rst", 32'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 3'b000;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 0, {31'h0, busy_v[0]}, 32'h0);

    // Pin the reference arithmetic itself.
    calc(16, 32'h7FFF, 32'h0, 1'b1, 1'b0, ms, mco, mov, mz);
    chk("model_7fff_sum", 1, ms, 32'h8000);
    chk("model_7fff_ovf", 1, {31'h0, mov}, 32'h1);
    calc(32, 32'h0, 32'h1, 1'b0, 1'b1, ms, mco, mov, mz);
    chk("model_0m1_sum",  0, ms, 32'hFFFF_FFFF);
    chk("model_0m1_cout", 0, {31'h0, mco}, 32'h0);

    // Carry through every slice.
    apply(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done(0, lat);
    chk("latency32", 0, lat, 32'd4);
    res_chk(0, "wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    pop(0);

    // Subtract with signed overflow; cin=1 must be ignored.
    apply(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1);
    wait_done(0, lat);
    res_chk(0, "sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    pop(0);

    // Subtract with borrow.
    apply(0, 32'h0, 32'h1, 1'b0, 1'b1);
    wait_done(0, lat);
    res_chk(0, "sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    pop(0);

    // Backpressure: result held, new requests ignored.
    apply(0, 32'h5, 32'h7, 1'b0, 1'b0);
    wait_done(0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i % 2 == 0);
      a_v[0] = $urandom; b_v[0] = $urandom;
      @(posedge clk); #1;
      res_chk(0, "bp_hold", 32'hC, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 0, {31'h0, in_ready_v[0]}, 32'h0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    chk("bp_in_ready_pre", 0, {31'h0, in_ready_v[0]}, 32'h0);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_in_ready_post", 0, {31'h0, in_ready_v[0]}, 32'h1);
    chk("bp_busy_post",     0, {31'h0, busy_v[0]},     32'h0);

    // Reset after two RUN cycles discards the operation.
    apply(0, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy",     0, {31'h0, busy_v[0]},      32'h0);
    chk("midrst_in_ready", 0, {31'h0, in_ready_v[0]}, 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 0, {31'h0, out_valid_v[0]}, 32'h0);
    end
    apply(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_done(0, lat);
    res_chk(0, "after_rst", 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    pop(0);

    // Narrow instances: boundary cases.
    apply(1, 32'h7FFF, 32'h0, 1'b1, 1'b0);
    wait_done(1, lat);
    chk("latency16", 1, lat, 32'd4);
    res_chk(1, "w16_7fff", 32'h8000, 1'b0, 1'b1, 1'b0);
    pop(1);

    apply(1, 32'h0, 32'h8000, 1'b0, 1'b1);
    wait_done(1, lat);
    res_chk(1, "w16_negmin", 32'h8000, 1'b0, 1'b1, 1'b0);
    pop(1);

    apply(2, 32'hFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done(2, lat);
    chk("latency24", 2, lat, 32'd3);
    res_chk(2, "w24_wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    pop(2);

    // Random operands on every instance, checked by the model each cycle.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 600; n++) begin
        apply(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wait_done(k, lat);
        chk("latency_rand", k, lat, nsl(k));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        pop(k);
      end
    end

    repeat (2) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
